// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN stream engine: FSM state encoding and
// counter-width helpers.
package cnn_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOADW,
        S_RUN,
        S_OUT
    } state_t;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_TAPS       = 4;
    localparam int unsigned DEF_POOL       = 4;
    localparam int unsigned DEF_LEAK_SHIFT = 3;

    // Index width for an n-entry counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_leaky_sat.sv
// Leaky-ReLU (arithmetic right shift for negatives) followed by saturation
// from the accumulator width down to the output data width.
module cnn_leaky_sat #(
    parameter int ACC_WIDTH  = 18,
    parameter int DATA_WIDTH = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_in,
    output logic signed [DATA_WIDTH-1:0] act_out
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_WIDTH-1:0] leak;

    always_comb begin
        leak = acc_in[ACC_WIDTH-1] ? (acc_in >>> LEAK_SHIFT) : acc_in;
        if (leak > SAT_MAX) begin
            act_out = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (leak < SAT_MIN) begin
            act_out = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            act_out = leak[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/cnn_stream_engine.sv
// Streaming 1-D convolution with max-pooling and leaky-ReLU activation:
// weights are loaded once, then pixels stream in and pooled results stream out.
module cnn_stream_engine
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TAPS       = 4,
    parameter int POOL       = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(TAPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_load,
    input  logic                         soft_clear,
    input  logic                         wt_valid,
    input  logic signed [DATA_WIDTH-1:0] wt_data,
    output logic                         wt_ready,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    input  logic                         out_ready,
    output logic                         busy
);

    localparam int unsigned TAP_W  = cnt_width(TAPS);
    localparam int unsigned PCNT_W = cnt_width(POOL);
    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(TAPS - 1);
    localparam logic [PCNT_W-1:0] POOL_LAST = PCNT_W'(POOL - 1);

    state_t                         state;
    logic signed [DATA_WIDTH-1:0]   weight [TAPS];
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    pmax;
    logic [TAP_W-1:0]               tap;
    logic [TAP_W-1:0]               widx;
    logic [PCNT_W-1:0]              pcnt;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    conv;
    logic signed [ACC_WIDTH-1:0]    win_max;
    logic signed [DATA_WIDTH-1:0]   act;

    // conv/win_max are only meaningful on the last tap of a window.
    always_comb begin
        prod    = (2*DATA_WIDTH)'(in_data) * (2*DATA_WIDTH)'(weight[tap]);
        conv    = acc + ACC_WIDTH'(prod);
        win_max = (pcnt == '0 || conv > pmax) ? conv : pmax;
    end

    cnn_leaky_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_leaky_sat (
        .acc_in  (win_max),
        .act_out (act)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            pmax      <= '0;
            tap       <= '0;
            widx      <= '0;
            pcnt      <= '0;
            out_data  <= '0;
            wt_ready  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                weight[i] <= '0;
            end
        end else if (soft_clear) begin
            state     <= S_IDLE;
            acc       <= '0;
            tap       <= '0;
            widx      <= '0;
            pcnt      <= '0;
            wt_ready  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_load) begin
                        state    <= S_LOADW;
                        widx     <= '0;
                        wt_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_LOADW: begin
                    if (wt_valid) begin
                        weight[widx] <= wt_data;
                        widx         <= widx + 1'b1;
                        if (widx == TAP_LAST) begin
                            state    <= S_RUN;
                            tap      <= '0;
                            pcnt     <= '0;
                            acc      <= '0;
                            wt_ready <= 1'b0;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        if (tap == TAP_LAST) begin
                            acc  <= '0;
                            tap  <= '0;
                            pmax <= win_max;
                            if (pcnt == POOL_LAST) begin
                                out_data  <= act;
                                pcnt      <= '0;
                                state     <= S_OUT;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                            end else begin
                                pcnt <= pcnt + 1'b1;
                            end
                        end else begin
                            acc <= conv;
                            tap <= tap + 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state     <= S_RUN;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    wt_ready  <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_stream_engine.sv
// Directed-plus-random bench for cnn_stream_engine against an arithmetic
// reference of convolution, max-pool, leaky activation and saturation.
module tb_cnn_stream_engine;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_load;
    logic              soft_clear;
    logic              wt_valid;
    logic signed [7:0] wt_data;
    logic              wt_ready;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic              out_ready;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;
    int got_q[$];
    int cur_w[4];
    int frame_px[16];
    int next_px[16];
    int held;
    int exp_a;

    cnn_stream_engine #(
        .DATA_WIDTH (8),
        .TAPS       (4),
        .POOL       (4),
        .LEAK_SHIFT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .soft_clear (soft_clear),
        .wt_valid   (wt_valid),
        .wt_data    (wt_data),
        .wt_ready   (wt_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Accepted results are captured mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) got_q.push_back(int'(out_data));
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference: 16 pixels -> 4 dot products -> max -> floor(x/8) if negative -> clamp.
    function automatic int model_frame(input int w[4], input int p[16]);
        int best = 0;
        for (int j = 0; j < 4; j++) begin
            int conv = 0;
            for (int t = 0; t < 4; t++) conv += p[4*j+t] * w[t];
            if (j == 0 || conv > best) best = conv;
        end
        if (best < 0) best = -((-best + 7) / 8);
        if (best > 127) best = 127;
        if (best < -128) best = -128;
        return best;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_engine();
        soft_clear = 1'b1;
        tick();
        soft_clear = 1'b0;
    endtask

    task automatic load_weights();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            wt_valid = 1'b1;
            wt_data  = 8'(cur_w[i]);
            while (!wt_ready && n < 50) begin tick(); n++; end
            if (!wt_ready) chk("wt_ready_timeout", 0, 1);
            tick();
        end
        wt_valid = 1'b0;
    endtask

    task automatic send_pixel(input int v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = 8'(v);
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < 16; i++) send_pixel(frame_px[i]);
    endtask

    task automatic wait_outputs(input int cnt);
        int n = 0;
        while (got_q.size() < cnt && n < 40) begin tick(); n++; end
        tick();
    endtask

    task automatic frame_check(input string tag);
        got_q.delete();
        send_frame();
        wait_outputs(1);
        chk({tag, "_count"}, got_q.size(), 1);
        if (got_q.size() > 0) chk(tag, got_q[0], model_frame(cur_w, frame_px));
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < 16; i++) frame_px[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) frame_px[i] = int'($urandom_range(255)) - 128;
    endtask

    task automatic set_weights(input int a, input int b, input int c, input int d);
        cur_w[0] = a; cur_w[1] = b; cur_w[2] = c; cur_w[3] = d;
    endtask

    initial begin
        rst = 1'b0; cfg_load = 1'b0; soft_clear = 1'b0;
        wt_valid = 1'b0; wt_data = '0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_wt_ready", int'(wt_ready), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        rst = 1'b1;
        tick();

        // All-ones weights and pixels, with the one-cycle output latency.
        set_weights(1, 1, 1, 1);
        load_weights();
        chk("run_busy", int'(busy), 1);
        chk("run_in_ready", int'(in_ready), 1);
        got_q.delete();
        fill_const(1);
        send_frame();
        chk("latency_out_valid", int'(out_valid), 1);
        chk("latency_out_data", int'(out_data), 4);
        wait_outputs(1);
        chk("ones_count", got_q.size(), 1);

        fill_const(-8);
        frame_check("neg8");
        fill_const(-1);
        frame_check("neg1_round");

        // Saturation both ways; cfg_load held high during a run must be ignored.
        clear_engine();
        set_weights(127, 127, 127, 127);
        load_weights();
        fill_const(127);
        cfg_load = 1'b1;
        frame_check("sat_pos");
        cfg_load = 1'b0;
        clear_engine();
        set_weights(-128, -128, -128, -128);
        load_weights();
        frame_check("sat_neg");

        // Random weights and pixels.
        clear_engine();
        set_weights(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                    int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
        load_weights();
        for (int k = 0; k < 4; k++) begin
            fill_random();
            frame_check("random");
        end

        // Back-pressure: output held, next pixel waiting, nothing accepted.
        fill_random();
        for (int i = 0; i < 16; i++) next_px[i] = int'($urandom_range(255)) - 128;
        got_q.delete();
        out_ready = 1'b0;
        send_frame();
        chk("bp_out_valid", int'(out_valid), 1);
        exp_a = model_frame(cur_w, frame_px);
        held = int'(out_data);
        chk("bp_out_data", held, exp_a);
        in_valid = 1'b1;
        in_data  = 8'(next_px[0]);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_stable", int'(out_data), held);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        chk("bp_no_pop", got_q.size(), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_pixel(next_px[i]);
        wait_outputs(2);
        chk("bp_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("bp_first", got_q[0], exp_a);
            chk("bp_next", got_q[1], model_frame(cur_w, next_px));
        end

        // soft_clear mid-frame with a colliding pixel beat, then a new weight set.
        fill_random();
        for (int i = 0; i < 6; i++) send_pixel(frame_px[i]);
        soft_clear = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'sd100;
        tick();
        soft_clear = 1'b0;
        in_valid   = 1'b0;
        chk("clr_busy", int'(busy), 0);
        chk("clr_in_ready", int'(in_ready), 0);
        set_weights(int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                    int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
        load_weights();
        fill_random();
        frame_check("after_clear");

        // Reset on the 10th pixel discards the frame.
        got_q.delete();
        fill_random();
        for (int i = 0; i < 9; i++) send_pixel(frame_px[i]);
        in_valid = 1'b1;
        in_data  = 8'(frame_px[9]);
        rst      = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_data", int'(out_data), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        chk("mid_rst_wt_ready", int'(wt_ready), 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_no_out", got_q.size(), 0);
        set_weights(3, -2, 5, 1);
        load_weights();
        fill_random();
        frame_check("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
